// File: rtl/sr_button_pkg.sv
// Shared state encoding and default timing constants for the SR-latch button front end.
package sr_button_pkg;

    localparam int DEBOUNCE_DEF = 16;
    localparam int PULSE_DEF    = 2;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t DRIVE_S = 2'd1;
    localparam state_t DRIVE_R = 2'd2;
    localparam state_t BLOCK   = 2'd3;

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchroniser, stability counter and one-cycle rising-edge pulse for one raw button.
module debounce_cell
    import sr_button_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF,
    parameter int CNT_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    if (DEBOUNCE < 1 || DEBOUNCE > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
        $error("debounce_cell: CNT_W too narrow for DEBOUNCE");
    end

    logic             sync1;
    logic             sync2;
    logic             level_prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            rise       <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1      <= din;
            sync2      <= sync1;
            level_prev <= level;
            // Registered edge keeps press latency at DEBOUNCE+3 edges end to end.
            rise       <= level & ~level_prev;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_button_ctrl.sv
// Turns two debounced buttons into mutually exclusive s/r pulses with a matching enable.
module sr_button_ctrl
    import sr_button_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF,
    parameter int CNT_W    = 5,
    parameter int PULSE    = PULSE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_s,
    input  logic btn_r,
    output logic s,
    output logic r,
    output logic en,
    output logic busy
);

    localparam int PW = $clog2(PULSE + 1);

    logic          db_s;
    logic          db_r;
    logic          p_s;
    logic          p_r;
    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nx;

    debounce_cell #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_db_s (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_s),
        .level (db_s),
        .rise  (p_s)
    );

    debounce_cell #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_db_r (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_r),
        .level (db_r),
        .rise  (p_r)
    );

    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        case (state)
            IDLE: begin
                // Any press that overlaps the other button is refused outright.
                if (p_s && p_r) begin
                    state_nx = BLOCK;
                end else if (p_s) begin
                    state_nx = db_r ? BLOCK : DRIVE_S;
                    pcnt_nx  = PW'(1);
                end else if (p_r) begin
                    state_nx = db_s ? BLOCK : DRIVE_R;
                    pcnt_nx  = PW'(1);
                end
            end
            DRIVE_S, DRIVE_R: begin
                if (pcnt == PW'(PULSE)) begin
                    state_nx = IDLE;
                    pcnt_nx  = '0;
                end else begin
                    pcnt_nx = pcnt + 1'b1;
                end
            end
            BLOCK: begin
                if (!db_s && !db_r) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx == IDLE || state_nx == BLOCK) begin
            pcnt_nx = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pcnt  <= '0;
            s     <= 1'b0;
            r     <= 1'b0;
            en    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            pcnt  <= pcnt_nx;
            s     <= (state_nx == DRIVE_S);
            r     <= (state_nx == DRIVE_R);
            en    <= (state_nx == DRIVE_S) || (state_nx == DRIVE_R);
            busy  <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_sr_button_ctrl.sv
// Directed and random checks of sr_button_ctrl driving a behavioural gated SR latch.
module tb_sr_button_ctrl;

    localparam int DEBOUNCE = 4;
    localparam int CNT_W    = 3;
    localparam int PULSE    = 2;
    localparam int NVEC     = 50;

    logic clk = 1'b0;
    logic rst;
    logic btn_s;
    logic btn_r;
    logic s;
    logic r;
    logic en;
    logic busy;
    logic q;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic bs;
        logic br;
        logic es;
        logic er;
        logic een;
        logic ebusy;
    } vec_t;

    vec_t vecs [NVEC];

    sr_button_ctrl #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W),
        .PULSE    (PULSE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_s (btn_s),
        .btn_r (btn_r),
        .s     (s),
        .r     (r),
        .en    (en),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Gated SR latch downstream of the controller.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            if (s && !r) q <= 1'b1;
            else if (r && !s) q <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 60; k++) begin
            if (!busy && !s && !r && !en) break;
            tick();
        end
        check(name, (k < 60) ? 1 : 0, 1);
    endtask

    task automatic count_pulses(input int cycles, output int ns, output int nr, output int ne);
        ns = 0;
        nr = 0;
        ne = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            ns += int'(s);
            nr += int'(r);
            ne += int'(en);
        end
    endtask

    initial begin
        int ns, nr, ne, edges, hold_s, hold_r, run;

        for (int i = 0; i < NVEC; i++) begin
            vecs[i].bs    = (i < 20);
            vecs[i].br    = (i >= 30 && i < 42) ? (((i - 30) / 2) % 2 == 0) : 1'b0;
            vecs[i].es    = (i == 7 || i == 8);
            vecs[i].er    = 1'b0;
            vecs[i].een   = (i == 7 || i == 8);
            vecs[i].ebusy = (i == 7 || i == 8);
        end

        rst   = 1'b1;
        btn_s = 1'b0;
        btn_r = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {s, r, en, busy}, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("post_reset_idle", {s, r, en, busy}, 0);

        // Clean press held 20 cycles, release, then fast bounce on btn_r.
        for (int i = 0; i < NVEC; i++) begin
            btn_s = vecs[i].bs;
            btn_r = vecs[i].br;
            tick();
            check($sformatf("vec%0d_s", i), s, vecs[i].es);
            check($sformatf("vec%0d_r", i), r, vecs[i].er);
            check($sformatf("vec%0d_en", i), en, vecs[i].een);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
            if (i == 19) check("latch_set", q, 1);
        end

        // Both buttons rise together.
        btn_s = 1'b1;
        btn_r = 1'b1;
        count_pulses(12, ns, nr, ne);
        check("both_no_drive", ns + nr + ne, 0);
        check("both_busy", busy, 1);
        btn_s = 1'b0;
        btn_r = 1'b0;
        repeat (6) tick();
        check("both_busy_before_db_fall", busy, 1);
        tick();
        check("both_busy_released", busy, 0);
        repeat (3) tick();

        // btn_r held, then btn_s pressed on top of it.
        btn_r = 1'b1;
        count_pulses(12, ns, nr, ne);
        check("held_r_pulse_r", nr, PULSE);
        check("held_r_pulse_en", ne, PULSE);
        check("held_r_no_s", ns, 0);
        check("latch_reset", q, 0);
        btn_s = 1'b1;
        count_pulses(12, ns, nr, ne);
        check("overlap_no_s", ns, 0);
        check("overlap_no_r_repeat", nr, 0);
        check("overlap_block", busy, 1);
        btn_s = 1'b0;
        btn_r = 1'b0;
        wait_idle("overlap_release");
        repeat (3) tick();

        // Reset mid-pulse, with btn_s still held afterwards.
        btn_s = 1'b1;
        edges = 0;
        while (!s && edges < 30) begin
            tick();
            edges++;
        end
        check("pre_rst_s_seen", s, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_s", s, 0);
        check("rst_async_en", en, 0);
        check("rst_async_busy", busy, 0);
        tick();
        #2 rst = 1'b0;
        edges = 0;
        while (!s && edges < 30) begin
            tick();
            edges++;
        end
        check("post_rst_latency", edges, DEBOUNCE + 4);
        ns = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            ns += int'(s);
        end
        check("post_rst_one_pulse", ns, PULSE);
        btn_s = 1'b0;
        wait_idle("post_rst_release");

        // Random button activity with invariant checks every cycle.
        hold_s = 1;
        hold_r = 1;
        run    = 0;
        for (int c = 0; c < 10000; c++) begin
            if (--hold_s == 0) begin
                btn_s  = ~btn_s;
                hold_s = $urandom_range(1, 14);
            end
            if (--hold_r == 0) begin
                btn_r  = ~btn_r;
                hold_r = $urandom_range(1, 14);
            end
            tick();
            check("rand_not_s_and_r", s & r, 0);
            check("rand_en_eq_s_or_r", en, s | r);
            if (en) begin
                run++;
            end else if (run != 0) begin
                check("rand_en_run", run, PULSE);
                run = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
